pwm_detect: RTL and testbench

- Hardware pulse-width detector for the PWM feedback path on the PmodENC/feedback header row (JD).
- Samples the PWM waveform returned on JD[3] and measures high time and period in sysclk cycles.
- Hands each completed measurement to the embedded system as a registered sample with a one-cycle valid strobe.
- Sits directly downstream of the EMBSYS pwm_out loop-back; firmware reads counts to compute duty cycle.

---
 rtl/pwm_detect_pkg.sv | 14 +
 rtl/pwm_edge_sync.sv | 73 +++++++
 rtl/pwm_detect.sv | 127 ++++++++++++
 tb/tb_pwm_detect.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/pwm_detect_pkg.sv
// Shared constants and FSM state encoding for the PWM feedback pulse-width detector.
package pwm_detect_pkg;

    localparam int DEGLITCH_LEN       = 4;
    localparam int CNT_W_DEF          = 32;
    localparam int TIMEOUT_CYCLES_DEF = 10_000_000;

    typedef logic [1:0] pwm_state_t;

    localparam pwm_state_t WAIT_RISE = 2'd0;
    localparam pwm_state_t MEAS_HIGH = 2'd1;
    localparam pwm_state_t MEAS_LOW  = 2'd2;

endpackage

// File: rtl/pwm_edge_sync.sv
// Synchroniser plus edge detector for an asynchronous level input.
// Define PWM_DETECT_DEGLITCH_EN to insert a 4-sample stable filter after the synchroniser.
module pwm_edge_sync
    import pwm_detect_pkg::*;
#(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic din,
    output logic level,
    output logic rise,
    output logic fall
);

    logic [SYNC_STAGES-1:0] sync_p0;
    logic                   sync_lvl;
    logic                   lvl_p1;
    logic                   lvl_d_p2;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_p0 <= '0;
        end else begin
            sync_p0 <= {sync_p0[SYNC_STAGES-2:0], din};
        end
    end

    assign sync_lvl = sync_p0[SYNC_STAGES-1];

    // ---- stage p1: optional deglitch filter ----
`ifdef PWM_DETECT_DEGLITCH_EN
    logic [DEGLITCH_LEN-2:0] hist_p1;
    logic [DEGLITCH_LEN-1:0] window;
    logic                    filt_p1;

    // The current synchronised sample completes the window, so a stable
    // run moves the filtered level exactly DEGLITCH_LEN cycles late.
    assign window = {hist_p1, sync_lvl};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hist_p1 <= '0;
            filt_p1 <= 1'b0;
        end else begin
            hist_p1 <= window[DEGLITCH_LEN-2:0];
            if (&window) begin
                filt_p1 <= 1'b1;
            end else if (~|window) begin
                filt_p1 <= 1'b0;
            end
        end
    end

    assign lvl_p1 = filt_p1;
`else
    assign lvl_p1 = sync_lvl;
`endif

    // ---- stage p2: delayed level for edge detection ----
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lvl_d_p2 <= 1'b0;
        end else begin
            lvl_d_p2 <= lvl_p1;
        end
    end

    assign level = lvl_p1;
    assign rise  = lvl_p1 & ~lvl_d_p2;
    assign fall  = ~lvl_p1 & lvl_d_p2;

endmodule

// File: rtl/pwm_detect.sv
// Measures high time and rise-to-rise period of the JD[3] PWM feedback in sysclk cycles.
// Optional PWM_DETECT_DEGLITCH_EN rejects input pulses shorter than 4 cycles.
module pwm_detect
    import pwm_detect_pkg::*;
#(
    parameter int CNT_W          = CNT_W_DEF,
    parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF,
    parameter int SYNC_STAGES    = 2
) (
    input  logic             sysclk,
    input  logic             sysreset_n,
    input  logic             pwm_in,
    output logic [CNT_W-1:0] high_count,
    output logic [CNT_W-1:0] period_count,
    output logic             sample_valid,
    output logic             stuck,
    output logic             stuck_level
);

    localparam int                IDLE_W    = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(TIMEOUT_CYCLES - 1);

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    logic              lvl;
    logic              rise;
    logic              fall;
    logic              any_edge;
    logic              timeout;
    pwm_state_t        state;
    logic [CNT_W-1:0]  hcnt;
    logic [CNT_W-1:0]  pcnt;
    logic [IDLE_W-1:0] idle_cnt;

    pwm_edge_sync #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_edge_sync (
        .clk  (sysclk),
        .rst_n(sysreset_n),
        .din  (pwm_in),
        .level(lvl),
        .rise (rise),
        .fall (fall)
    );

    assign any_edge = rise | fall;
    // An edge in the expiry cycle wins, so the timeout never fires on it.
    assign timeout  = !any_edge && !stuck && (idle_cnt == IDLE_LAST);

    always_ff @(posedge sysclk or negedge sysreset_n) begin
        if (!sysreset_n) begin
            idle_cnt <= '0;
            stuck       <= 1'b0;
            stuck_level <= 1'b0;
        end else begin
            if (any_edge) begin
                idle_cnt <= '0;
            end else if (idle_cnt != IDLE_LAST) begin
                idle_cnt <= idle_cnt + IDLE_W'(1);
            end

            if (any_edge) begin
                stuck <= 1'b0;
            end else if (timeout) begin
                stuck       <= 1'b1;
                stuck_level <= lvl;
            end
        end
    end

    // ---- stage p3: measurement FSM and registered sample ----
    always_ff @(posedge sysclk or negedge sysreset_n) begin
        if (!sysreset_n) begin
            state        <= WAIT_RISE;
            hcnt         <= '0;
            pcnt         <= '0;
            high_count   <= '0;
            period_count <= '0;
            sample_valid <= 1'b0;
        end else begin
            sample_valid <= 1'b0;
            if (timeout) begin
                state <= WAIT_RISE;
                hcnt  <= '0;
                pcnt  <= '0;
            end else begin
                case (state)
                    WAIT_RISE: begin
                        if (rise) begin
                            state <= MEAS_HIGH;
                            hcnt  <= CNT_W'(1);
                            pcnt  <= CNT_W'(1);
                        end
                    end
                    MEAS_HIGH: begin
                        pcnt <= sat_inc(pcnt);
                        if (fall) begin
                            state <= MEAS_LOW;
                        end else begin
                            hcnt <= sat_inc(hcnt);
                        end
                    end
                    MEAS_LOW: begin
                        if (rise) begin
                            high_count   <= hcnt;
                            period_count <= pcnt;
                            sample_valid <= 1'b1;
                            state        <= MEAS_HIGH;
                            hcnt         <= CNT_W'(1);
                            pcnt         <= CNT_W'(1);
                        end else begin
                            pcnt <= sat_inc(pcnt);
                        end
                    end
                    default: begin
                        state <= WAIT_RISE;
                        hcnt  <= '0;
                        pcnt  <= '0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_pwm_detect.sv
// Directed bench for pwm_detect with a timestamp-based reference model and literal spot checks.
module tb_pwm_detect;

    localparam int CNT_W   = 8;
    localparam int TIMEOUT = 1000;
    localparam int SYNC    = 2;
    localparam int MAXC    = (1 << CNT_W) - 1;
`ifdef PWM_DETECT_DEGLITCH_EN
    localparam int DLY = SYNC + 1;
`else
    localparam int DLY = SYNC;
`endif

    logic             sysclk = 1'b0;
    logic             sysreset_n = 1'b0;
    logic             pwm_in = 1'b0;
    logic [CNT_W-1:0] high_count;
    logic [CNT_W-1:0] period_count;
    logic             sample_valid;
    logic             stuck;
    logic             stuck_level;

    always #5 sysclk = ~sysclk;

    pwm_detect #(
        .CNT_W         (CNT_W),
        .TIMEOUT_CYCLES(TIMEOUT),
        .SYNC_STAGES   (SYNC)
    ) dut (
        .sysclk      (sysclk),
        .sysreset_n  (sysreset_n),
        .pwm_in      (pwm_in),
        .high_count  (high_count),
        .period_count(period_count),
        .sample_valid(sample_valid),
        .stuck       (stuck),
        .stuck_level (stuck_level)
    );

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d (cycle %0d)", name, act, req, cyc);
        end
    endtask

    function automatic int sat(input int v);
        return (v > MAXC) ? MAXC : v;
    endfunction

    typedef struct {
        int hc;
        int pc;
        int sv;
        int st;
        int sl;
    } exp_t;

    // Model: events are timestamps of the input stream; a sample is owed on a
    // rise when an armed rise and a later fall precede it. Outputs appear DLY cycles later.
    exp_t     pipe[$];
    exp_t     cur;
    bit [3:0] win;
    bit       e_lvl;
    bit       x_prev;
    bit       armed;
    bit       fall_seen;
    int       rise_t;
    int       fall_t;
    int       last_edge;

    int sh[$];
    int sp[$];
    int strobe_cyc = -1;
    int stuck_cyc = -1;
    bit stuck_q = 1'b0;

    always @(posedge sysclk) begin
        exp_t due;
        bit   x;
        bit   rs;
        bit   fl;
        cyc++;
        if (!sysreset_n) begin
            cur       = '{0, 0, 0, 0, 0};
            armed     = 1'b0;
            fall_seen = 1'b0;
            x_prev    = 1'b0;
            win       = '0;
            e_lvl     = 1'b0;
            last_edge = cyc;
            pipe.delete();
            for (int i = 0; i < DLY; i++) pipe.push_back(cur);
        end else begin
            win = {win[2:0], pwm_in};
`ifdef PWM_DETECT_DEGLITCH_EN
            if (win == 4'hF) e_lvl = 1'b1;
            else if (win == 4'h0) e_lvl = 1'b0;
            x = e_lvl;
`else
            x = pwm_in;
`endif
            rs = x && !x_prev;
            fl = !x && x_prev;
            x_prev = x;
            cur.sv = 0;
            if (rs) begin
                if (armed && fall_seen) begin
                    cur.sv = 1;
                    cur.hc = sat(fall_t - rise_t);
                    cur.pc = sat(cyc - rise_t);
                end
                armed     = 1'b1;
                fall_seen = 1'b0;
                rise_t    = cyc;
            end
            if (fl && armed) begin
                fall_t    = cyc;
                fall_seen = 1'b1;
            end
            if (rs || fl) begin
                cur.st    = 0;
                last_edge = cyc;
            end else if (cur.st == 0 && (cyc - last_edge) == TIMEOUT) begin
                cur.st = 1;
                cur.sl = int'(x);
                armed  = 1'b0;
            end
        end
        pipe.push_back(cur);
        due = pipe.pop_front();
        #1;
        chk("model_high_count", int'(high_count), due.hc);
        chk("model_period_count", int'(period_count), due.pc);
        chk("model_sample_valid", int'(sample_valid), due.sv);
        chk("model_stuck", int'(stuck), due.st);
        chk("model_stuck_level", int'(stuck_level), due.sl);
        if (sample_valid) begin
            sh.push_back(int'(high_count));
            sp.push_back(int'(period_count));
            strobe_cyc = cyc;
        end
        if (stuck && !stuck_q) stuck_cyc = cyc;
        stuck_q = stuck;
    end

    task automatic drive(input bit v, input int n);
        pwm_in = v;
        repeat (n) @(negedge sysclk);
    endtask

    task automatic chk_zero_outputs(input string tag);
        chk({tag, "_high_count"}, int'(high_count), 0);
        chk({tag, "_period_count"}, int'(period_count), 0);
        chk({tag, "_sample_valid"}, int'(sample_valid), 0);
        chk({tag, "_stuck"}, int'(stuck), 0);
        chk({tag, "_stuck_level"}, int'(stuck_level), 0);
    endtask

    initial begin
        int n1;
        int n2;
        int n3;
        sysreset_n = 1'b0;
        pwm_in     = 1'b0;
        repeat (3) @(negedge sysclk);
        chk_zero_outputs("reset");
        sysreset_n = 1'b1;

        // Square wave 30/70, then duty change to 90/10, then held high.
        drive(0, 10);
        repeat (5) begin drive(1, 30); drive(0, 70); end
        repeat (3) begin drive(1, 90); drive(0, 10); end
        drive(1, 1100);

        chk("run_strobe_count", sh.size(), 8);
        for (int i = 0; i < 5; i++) begin
            chk("run_high_30", sh[i], 30);
            chk("run_period_100", sp[i], 100);
        end
        for (int i = 5; i < 8; i++) begin
            chk("run_high_90", sh[i], 90);
            chk("run_period_100b", sp[i], 100);
        end
        chk("stuck_delay", stuck_cyc - strobe_cyc, TIMEOUT);
        chk("stuck_set", int'(stuck), 1);
        chk("stuck_level_high", int'(stuck_level), 1);
        chk("stuck_keeps_high", int'(high_count), 90);
        chk("stuck_keeps_period", int'(period_count), 100);

        // Fall out of stuck, then a saturating period.
        n1 = sh.size();
        drive(0, 50);
        chk("stuck_cleared", int'(stuck), 0);
        chk("no_strobe_after_fall", sh.size(), n1);
        drive(1, 200);
        drive(0, 200);
        chk("no_strobe_first_period", sh.size(), n1);
        drive(1, 20);
        chk("sat_strobe_count", sh.size(), n1 + 1);
        chk("sat_high_200", sh[n1], 200);
        chk("sat_period_255", sp[n1], MAXC);

        // Asynchronous reset in the middle of the low phase.
        drive(0, 30);
        #3 sysreset_n = 1'b0;
        #1 chk_zero_outputs("async_reset");
        repeat (3) @(negedge sysclk);
        sysreset_n = 1'b1;
        n2 = sh.size();
        drive(0, 10);
        drive(1, 20);
        drive(0, 20);
        chk("no_strobe_before_second_rise", sh.size(), n2);
        drive(1, 10);
        chk("post_reset_strobe_count", sh.size(), n2 + 1);
        chk("post_reset_high", sh[n2], 20);
        chk("post_reset_period", sp[n2], 40);

        // 2-cycle low glitch inside a 50-cycle high pulse.
        drive(0, 20);
        drive(1, 20);
        drive(0, 2);
        drive(1, 28);
        drive(0, 50);
        drive(1, 10);
        drive(0, 20);
        n3 = sh.size();
`ifdef PWM_DETECT_DEGLITCH_EN
        chk("glitch_filtered_high", sh[n3-1], 50);
        chk("glitch_filtered_period", sp[n3-1], 100);
`else
        chk("glitch_first_high", sh[n3-2], 20);
        chk("glitch_first_period", sp[n3-2], 22);
        chk("glitch_second_high", sh[n3-1], 28);
        chk("glitch_second_period", sp[n3-1], 78);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
